// File: rtl/hamm_pkg.sv
// Shared Hamming(7,4) definitions: receive FSM states, widths, and a data-bit
// extractor for the p1 p2 d1 p4 d2 d3 d4 codeword layout.
package hamm_pkg;

  localparam int unsigned HAMM_W    = 7;
  localparam int unsigned DATA_W    = 4;
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

  typedef logic [0:HAMM_W-1] codeword_t;

  // Returns {d4, d3, d2, d1} from positions 6, 5, 4, 2.
  function automatic logic [DATA_W-1:0] hamm_data(input codeword_t cw);
    return {cw[6], cw[5], cw[4], cw[2]};
  endfunction

endpackage

// File: rtl/hamm_rx_deser_if.sv
// Codeword valid/ready channel between the receive deserializer and error_correct.
interface hamm_rx_deser_if;

  hamm_pkg::codeword_t d_hamm;
  logic                hamm_valid;
  logic                hamm_ready;

  modport master (
    output d_hamm,
    output hamm_valid,
    input  hamm_ready
  );

  modport slave (
    input  d_hamm,
    input  hamm_valid,
    output hamm_ready
  );

endinterface

// File: rtl/hamm_obuf.sv
// One-entry valid/ready output register with overrun detection and a
// wrapping count of accepted codewords.
module hamm_obuf
  import hamm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  codeword_t        i_data,
  hamm_rx_deser_if.master  hamm,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_frm_cnt
);

  codeword_t        r_data;
  logic             r_valid;
  logic             r_overrun;
  logic [CNT_W-1:0] r_frm_cnt;
  logic             w_xfer;
  logic             w_accept_new;

  assign w_xfer       = r_valid && hamm.hamm_ready;
  // An occupied slot can still take a new frame if it drains on this edge.
  assign w_accept_new = i_load && (!r_valid || hamm.hamm_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_frm_cnt <= '0;
    end else begin
      r_overrun <= i_load && !w_accept_new;
      if (w_accept_new) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_xfer) begin
        r_frm_cnt <= r_frm_cnt + CNT_W'(1);
      end
    end
  end

  assign hamm.d_hamm     = r_data;
  assign hamm.hamm_valid = r_valid;
  assign o_overrun       = r_overrun;
  assign o_frm_cnt       = r_frm_cnt;

endmodule

// File: rtl/hamm_rx_deser.sv
// Serial receive front end: frames start/7-bit/stop sequences into codewords
// and hands them to error_correct through a one-entry output buffer.
module hamm_rx_deser
  import hamm_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_bit,
  input  logic             rx_en,
  hamm_rx_deser_if.master  hamm,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] frm_cnt
);

  rx_state_t              r_state;
  logic [BIT_IDX_W-1:0]   r_bit_idx;
  codeword_t              r_shreg;
  logic                   r_frame_err;
  logic                   w_frame_done;

  // Completion is taken combinationally so the buffer loads on the stop-bit edge.
  assign w_frame_done = rx_en && (r_state == STOP) && rx_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (rx_en) begin
        unique case (r_state)
          IDLE: begin
            if (!rx_bit) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end
          end
          DATA: begin
            r_shreg[r_bit_idx] <= rx_bit;
            if (r_bit_idx == BIT_IDX_W'(HAMM_W - 1)) begin
              r_state   <= STOP;
              r_bit_idx <= '0;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
            end
          end
          STOP: begin
            r_state     <= IDLE;
            r_frame_err <= !rx_bit;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign frame_err = r_frame_err;

  hamm_obuf #(
    .CNT_W (CNT_W)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_frame_done),
    .i_data    (r_shreg),
    .hamm      (hamm),
    .o_overrun (overrun),
    .o_frm_cnt (frm_cnt)
  );

endmodule

// File: tb/tb_hamm_rx_deser.sv
// Self-checking bench for hamm_rx_deser: directed scenarios plus randomized
// traffic compared against a frame-level reference model.
module tb_hamm_rx_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_bit;
  logic       rx_en;
  logic       frame_err;
  logic       overrun;
  logic [7:0] frm_cnt;

  int checks   = 0;
  int failures = 0;

  hamm_rx_deser_if u_if ();

  hamm_rx_deser #(
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_bit    (rx_bit),
    .rx_en     (rx_en),
    .hamm      (u_if),
    .frame_err (frame_err),
    .overrun   (overrun),
    .frm_cnt   (frm_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: collects 8 strobed bits after a start bit, then applies
  // the one-slot buffer rules to the resulting frame.
  logic       m_busy;
  logic       m_bits[$];
  logic [0:6] m_q[$];
  logic [0:6] m_last;
  logic [7:0] m_cnt;
  logic       m_ferr;
  logic       m_ovr;

  always @(posedge clk) begin
    logic       done;
    logic [0:6] cw;
    done = 1'b0;
    cw   = '0;
    if (rst) begin
      m_busy = 1'b0;
      m_bits.delete();
      m_q.delete();
      m_last = '0;
      m_cnt  = '0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (rx_en) begin
        if (!m_busy) begin
          if (rx_bit == 1'b0) begin
            m_busy = 1'b1;
            m_bits.delete();
          end
        end else begin
          m_bits.push_back(rx_bit);
          if (m_bits.size() == 8) begin
            m_busy = 1'b0;
            for (int i = 0; i < 7; i++) cw[i] = m_bits[i];
            if (m_bits[7]) done = 1'b1;
            else m_ferr = 1'b1;
          end
        end
      end
      if (m_q.size() != 0 && u_if.hamm_ready) begin
        void'(m_q.pop_front());
        m_cnt = m_cnt + 8'd1;
      end
      if (done) begin
        if (m_q.size() == 0) begin
          m_q.push_back(cw);
          m_last = cw;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  end

  logic ferr_seen, ovr_seen;
  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_seen = 1'b1;
    if (overrun === 1'b1) ovr_seen = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_en = 1'b0; rx_bit = 1'b1; u_if.hamm_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Leaves rx_en high with an idle level so the next frame can follow directly.
  task automatic send_frame(input logic [0:6] cw, input logic stop, input logic rdy_at_stop);
    rx_en = 1'b1; rx_bit = 1'b0; cyc();
    for (int i = 0; i < 7; i++) begin
      rx_bit = cw[i]; cyc();
    end
    rx_bit = stop;
    if (rdy_at_stop) u_if.hamm_ready = 1'b1;
    cyc();
    rx_bit = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (u_if.hamm_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", u_if.hamm_valid); end
    if (u_if.d_hamm !== 7'b0) begin failures++; $display("FAIL rst_d_hamm got=%b exp=0000000", u_if.d_hamm); end
    if (frm_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", frm_cnt); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_ferr got=%b exp=0", frame_err); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL rst_ovr got=%b exp=0", overrun); end
  endtask

  task automatic test_single();
    do_reset();
    u_if.hamm_ready = 1'b1;
    send_frame(7'b0111111, 1'b1, 1'b0);
    rx_en = 1'b0;
    checks += 3;
    if (u_if.hamm_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", u_if.hamm_valid); end
    if (u_if.d_hamm !== 7'b0111111) begin failures++; $display("FAIL single_data got=%b exp=0111111", u_if.d_hamm); end
    if (frm_cnt !== 8'd0) begin failures++; $display("FAIL single_cnt_pre got=%0d exp=0", frm_cnt); end
    cyc();
    checks += 2;
    if (u_if.hamm_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop got=%b exp=0", u_if.hamm_valid); end
    if (frm_cnt !== 8'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", frm_cnt); end
  endtask

  task automatic test_frame_err();
    do_reset();
    u_if.hamm_ready = 1'b1;
    send_frame(7'b0111111, 1'b0, 1'b0);
    rx_en = 1'b0;
    checks += 2;
    if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
    if (u_if.hamm_valid !== 1'b0) begin failures++; $display("FAIL ferr_valid got=%b exp=0", u_if.hamm_valid); end
    cyc();
    checks += 3;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_width got=%b exp=0", frame_err); end
    if (u_if.hamm_valid !== 1'b0) begin failures++; $display("FAIL ferr_valid2 got=%b exp=0", u_if.hamm_valid); end
    if (frm_cnt !== 8'd0) begin failures++; $display("FAIL ferr_cnt got=%0d exp=0", frm_cnt); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(7'b1010101, 1'b1, 1'b0);
    checks += 2;
    if (u_if.hamm_valid !== 1'b1) begin failures++; $display("FAIL ovr_first_valid got=%b exp=1", u_if.hamm_valid); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_first_ovr got=%b exp=0", overrun); end
    send_frame(7'b0011001, 1'b1, 1'b0);
    rx_en = 1'b0;
    checks += 3;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
    if (u_if.d_hamm !== 7'b1010101) begin failures++; $display("FAIL ovr_data_kept got=%b exp=1010101", u_if.d_hamm); end
    if (u_if.hamm_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", u_if.hamm_valid); end
    cyc();
    checks += 1;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_width got=%b exp=0", overrun); end
    u_if.hamm_ready = 1'b1;
    cyc();
    checks += 3;
    if (u_if.hamm_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain_valid got=%b exp=0", u_if.hamm_valid); end
    if (frm_cnt !== 8'd1) begin failures++; $display("FAIL ovr_drain_cnt got=%0d exp=1", frm_cnt); end
    if (u_if.d_hamm !== 7'b1010101) begin failures++; $display("FAIL ovr_drain_data got=%b exp=1010101", u_if.d_hamm); end
    cyc(); cyc();
    checks += 2;
    if (u_if.hamm_valid !== 1'b0) begin failures++; $display("FAIL ovr_no_second got=%b exp=0", u_if.hamm_valid); end
    if (frm_cnt !== 8'd1) begin failures++; $display("FAIL ovr_final_cnt got=%0d exp=1", frm_cnt); end
  endtask

  task automatic test_simul_load_accept();
    do_reset();
    send_frame(7'b1010101, 1'b1, 1'b0);
    send_frame(7'b0011001, 1'b1, 1'b1);
    rx_en = 1'b0;
    checks += 4;
    if (u_if.hamm_valid !== 1'b1) begin failures++; $display("FAIL sim_valid got=%b exp=1", u_if.hamm_valid); end
    if (u_if.d_hamm !== 7'b0011001) begin failures++; $display("FAIL sim_data got=%b exp=0011001", u_if.d_hamm); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL sim_ovr got=%b exp=0", overrun); end
    if (frm_cnt !== 8'd1) begin failures++; $display("FAIL sim_cnt got=%0d exp=1", frm_cnt); end
    cyc();
    checks += 2;
    if (u_if.hamm_valid !== 1'b0) begin failures++; $display("FAIL sim_valid2 got=%b exp=0", u_if.hamm_valid); end
    if (frm_cnt !== 8'd2) begin failures++; $display("FAIL sim_cnt2 got=%0d exp=2", frm_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    u_if.hamm_ready = 1'b1;
    rx_en = 1'b1; rx_bit = 1'b0; cyc();
    for (int i = 0; i < 4; i++) begin
      rx_bit = 1'b1; cyc();
    end
    rst = 1'b1; rx_bit = 1'b1; cyc();
    rst = 1'b0;
    checks += 5;
    if (u_if.hamm_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", u_if.hamm_valid); end
    if (u_if.d_hamm !== 7'b0) begin failures++; $display("FAIL mid_data got=%b exp=0000000", u_if.d_hamm); end
    if (frm_cnt !== 8'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", frm_cnt); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL mid_ferr got=%b exp=0", frame_err); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL mid_ovr got=%b exp=0", overrun); end
    send_frame(7'b1100110, 1'b1, 1'b0);
    rx_en = 1'b0;
    checks += 3;
    if (u_if.hamm_valid !== 1'b1) begin failures++; $display("FAIL mid_new_valid got=%b exp=1", u_if.hamm_valid); end
    if (u_if.d_hamm !== 7'b1100110) begin failures++; $display("FAIL mid_new_data got=%b exp=1100110", u_if.d_hamm); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL mid_new_ferr got=%b exp=0", frame_err); end
    cyc();
    checks += 2;
    if (frm_cnt !== 8'd1) begin failures++; $display("FAIL mid_new_cnt got=%0d exp=1", frm_cnt); end
    if (u_if.hamm_valid !== 1'b0) begin failures++; $display("FAIL mid_new_valid2 got=%b exp=0", u_if.hamm_valid); end
  endtask

  task automatic test_counter_wrap();
    logic [0:6] cw;
    do_reset();
    u_if.hamm_ready = 1'b1;
    ferr_seen = 1'b0;
    ovr_seen  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cw = 7'($urandom);
      send_frame(cw, 1'b1, 1'b0);
      checks += 2;
      if (u_if.d_hamm !== cw || u_if.hamm_valid !== 1'b1) begin
        failures++;
        $display("FAIL wrap_frame%0d got=%b/%b exp=%b/1", i, u_if.d_hamm, u_if.hamm_valid, cw);
      end
      if (frm_cnt !== 8'(i)) begin failures++; $display("FAIL wrap_cnt%0d got=%0d exp=%0d", i, frm_cnt, i); end
    end
    rx_en = 1'b0;
    cyc();
    checks += 3;
    if (frm_cnt !== 8'd0) begin failures++; $display("FAIL wrap_final_cnt got=%0d exp=0", frm_cnt); end
    if (ferr_seen !== 1'b0) begin failures++; $display("FAIL wrap_ferr got=%b exp=0", ferr_seen); end
    if (ovr_seen !== 1'b0) begin failures++; $display("FAIL wrap_ovr got=%b exp=0", ovr_seen); end
  endtask

  task automatic test_random();
    logic       q[$];
    logic [0:6] cw;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) q.push_back(1'b1);
      q.push_back(1'b0);
      cw = 7'($urandom);
      for (int i = 0; i < 7; i++) q.push_back(cw[i]);
      q.push_back($urandom_range(0, 9) != 0);
    end
    while (q.size() != 0) begin
      rx_en = ($urandom_range(0, 3) != 0);
      if (rx_en) rx_bit = q.pop_front();
      else rx_bit = 1'($urandom_range(0, 1));
      u_if.hamm_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
      cyc();
      checks += 5;
      if (u_if.hamm_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_valid t=%0t got=%b exp=%b", $time, u_if.hamm_valid, m_q.size() != 0); end
      if (u_if.d_hamm !== m_last) begin failures++; $display("FAIL rnd_data t=%0t got=%b exp=%b", $time, u_if.d_hamm, m_last); end
      if (frame_err !== m_ferr) begin failures++; $display("FAIL rnd_ferr t=%0t got=%b exp=%b", $time, frame_err, m_ferr); end
      if (overrun !== m_ovr) begin failures++; $display("FAIL rnd_ovr t=%0t got=%b exp=%b", $time, overrun, m_ovr); end
      if (frm_cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt t=%0t got=%0d exp=%0d", $time, frm_cnt, m_cnt); end
    end
    rst = 1'b0; rx_en = 1'b0; rx_bit = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rx_en = 1'b0; rx_bit = 1'b1; u_if.hamm_ready = 1'b0;
    test_reset();
    test_single();
    test_frame_err();
    test_overrun();
    test_simul_load_accept();
    test_reset_mid_frame();
    test_counter_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamm_rx_deser.md
# hamm_rx_deser

Serial receive front end for the Hamming(7,4) path. It frames a serial bitstream into 7-bit codewords and presents each codeword on `d_hamm[0:6]` to the downstream `error_correct` stage through a valid/ready handshake. It also flags framing errors and output overruns, and counts delivered codewords.

## Interface
**Parameters**
- `CNT_W`, default 8: width of the delivered-frame counter.

**Ports**
- `clk`, input, 1: single system clock. All logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rx_bit`, input, 1: serial line. Idle level is 1.
- `rx_en`, input, 1: bit strobe. `rx_bit` is sampled only in cycles where `rx_en` = 1.
- `d_hamm`, output, [0:6]: codeword to `error_correct`. Bit 0 is the first bit received.
- `hamm_valid`, output, 1: `d_hamm` holds an undelivered codeword.
- `hamm_ready`, input, 1: downstream accepts the codeword.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is 0.
- `overrun`, output, 1: one-cycle pulse when a completed frame is dropped because the buffer is full.
- `frm_cnt`, output, `CNT_W`: count of codewords accepted downstream. Wraps modulo 2^`CNT_W`.

## Operation
- **Frame format:** start bit (0), then 7 codeword bits in order `d_hamm[0]` … `d_hamm[6]`, then stop bit (1). Codeword positions are p1 p2 d1 p4 d2 d3 d4.
- **FSM states and transitions.** All transitions advance only on `rx_en` cycles.
  - IDLE: moves to DATA when `rx_bit` = 0; otherwise stays in IDLE.
  - DATA: shifts the sampled bit into shift register position `bit_idx` (3-bit counter, 0..6). After index 6 it moves to STOP.
  - STOP:
    - `rx_bit` = 1 → frame complete; return to IDLE.
    - `rx_bit` = 0 → pulse `frame_err`, discard the frame, return to IDLE. No resync hunt: the next 0 sampled in IDLE is treated as a new start bit.
- **Output buffer (1 entry):**
  - Frame complete with buffer empty, or with buffer full and `hamm_ready` = 1 in the same cycle: load `d_hamm`, set `hamm_valid` = 1.
  - Frame complete with buffer full and `hamm_ready` = 0: pulse `overrun`, drop the new frame. `d_hamm` is unchanged.
  - `hamm_valid` && `hamm_ready` with no completion: clear `hamm_valid`. `d_hamm` holds its last value.
  - `frm_cnt` increments on every transfer (`hamm_valid` && `hamm_ready`).
- The block performs no syndrome checking; correction belongs to `error_correct`.
- **Reset:** state IDLE, `bit_idx` = 0, shift register = 0, `d_hamm` = 7'b0000000, `hamm_valid` = 0, `frame_err` = 0, `overrun` = 0, `frm_cnt` = 0.
- A reset in the middle of a frame aborts it. The partial frame is never delivered and no error pulse is produced.

## Timing
- The stop bit is sampled at cycle N. `d_hamm` and `hamm_valid` are valid from cycle N+1. All outputs are registered.
- `frame_err` and `overrun` are high exactly in cycle N+1 of the offending frame.
- The transfer occurs on the clock edge where `hamm_valid` && `hamm_ready`.
  - `hamm_valid` = 0 in the next cycle unless a new frame loads on that same edge, in which case `hamm_valid` stays 1 with the new `d_hamm`.
- `hamm_ready` may be high when `hamm_valid` = 0; this has no effect.
- `rx_en` may be asserted every cycle. Minimum frame length is 9 strobes. Back-to-back frames need no idle strobe between them.
- Cycles with `rx_en` = 0 freeze the FSM and shift register. They do not freeze the handshake.

## Structure
- Shared package `hamm_pkg` contains:
  - FSM state type: IDLE, DATA, STOP.
  - Constants `HAMM_W` = 7, `DATA_W` = 4, `BIT_IDX_W` = 3.
  - Also reused by `error_correct` and any future encoder.
- One natural sub-module, `hamm_obuf`: the 1-entry valid/ready output register with overrun detect. The FSM and shift register stay in the top module.

## Test plan
- **Single frame:**
  - Stimulus: strobes 0, 0,1,1,1,1,1,1, 1 with `hamm_ready` = 1.
  - Response: `d_hamm` = 7'b0111111, `hamm_valid` high for 1 cycle, `frm_cnt` = 1.
- **Framing error:**
  - Stimulus: same bits, stop bit = 0.
  - Response: `frame_err` pulse in cycle N+1, `hamm_valid` stays 0, `frm_cnt` = 0.
- **Overrun:**
  - Stimulus: `hamm_ready` = 0; send 7'b1010101, then 7'b0011001.
  - Response: `overrun` pulse after the second frame; `d_hamm` stays 7'b1010101. Raising ready delivers only 7'b1010101.
- **Simultaneous load and accept:**
  - Stimulus: ready rises in the same cycle the second frame completes.
  - Response: `hamm_valid` stays 1, `d_hamm` = 7'b0011001, no `overrun`, `frm_cnt` = 1, then 2 after the next accept.
- **Reset mid-frame:**
  - Stimulus: assert `rst` after 4 data bits, then send a full 7'b1100110 frame.
  - Response: all outputs 0 after reset; only 7'b1100110 is delivered.
- **Counter wrap:**
  - Stimulus: 256 back-to-back frames with `rx_en` = 1 every cycle.
  - Response: `frm_cnt` = 0, no `frame_err`, no `overrun`.
